// File: rtl/reg_writeback_pkg.sv
// Shared GPR write-side definitions: register file geometry, write payload and result source select.
package reg_writeback_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;
    localparam int unsigned REG_NUM    = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = REG_ADDR_W'(0);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] wa;
        logic [REG_DATA_W-1:0] wd;
    } wb_req_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_LU   = 2'd2
    } wb_src_e;

    function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] a);
        return a == REG_ZERO;
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write bitmap, outstanding long-op credit counter and decode hazard lookups.
module wb_scoreboard
    import reg_writeback_pkg::*;
#(
    parameter int unsigned LU_MAX = 4,
    parameter int unsigned CNT_W  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_wa,
    input  logic                  issue_long,
    input  logic                  lu_done,
    input  logic                  commit_we,
    input  logic [REG_ADDR_W-1:0] commit_wa,
    input  logic [REG_ADDR_W-1:0] ra1,
    input  logic [REG_ADDR_W-1:0] ra2,
    output logic                  issue_ready,
    output logic                  haz1,
    output logic                  haz2
);

    logic [REG_NUM-1:0] pend_q, pend_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               issue_acc;
    logic               long_acc;

    // A completing long op frees its credit in the same cycle a new one may claim it.
    always_comb begin
        issue_ready = ~issue_long | (cnt_q < CNT_W'(LU_MAX)) | lu_done;
        issue_acc   = issue_valid & issue_ready;
        long_acc    = issue_acc & issue_long;
    end

    // Clear on commit first, then set on issue, so a younger writer survives a same-edge commit.
    always_comb begin
        pend_d = pend_q;
        if (commit_we) begin
            pend_d[commit_wa] = 1'b0;
        end
        if (issue_acc && !is_zero_reg(issue_wa)) begin
            pend_d[issue_wa] = 1'b1;
        end
    end

    // Spurious completions with nothing outstanding leave the counter at zero.
    always_comb begin
        cnt_d = cnt_q;
        case ({long_acc, lu_done})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign haz1 = pend_q[ra1] & ~is_zero_reg(ra1);
    assign haz2 = pend_q[ra2] & ~is_zero_reg(ra2);

endmodule

// File: rtl/reg_writeback.sv
// GPR write-port owner: ALU-priority result arbitration, registered write port and hazard scoreboard.
module reg_writeback
    import reg_writeback_pkg::*;
#(
    parameter int unsigned LU_MAX = 4,
    parameter int unsigned CNT_W  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_wa,
    input  logic                  issue_long,
    output logic                  issue_ready,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_wa,
    input  logic [REG_DATA_W-1:0] alu_wd,
    input  logic                  lu_valid,
    input  logic [REG_ADDR_W-1:0] lu_wa,
    input  logic [REG_DATA_W-1:0] lu_wd,
    output logic                  lu_ready,
    input  logic [REG_ADDR_W-1:0] ra1,
    input  logic [REG_ADDR_W-1:0] ra2,
    output logic                  haz1,
    output logic                  haz2,
    output logic                  we,
    output logic [REG_ADDR_W-1:0] wa,
    output logic [REG_DATA_W-1:0] wd
);

    wb_src_e src;
    wb_req_t req;
    wb_req_t out_q, out_d;
    logic    we_q, we_d;

    // ALU has no backpressure, so it always wins; the long unit holds its result until a free slot.
    always_comb begin
        src = SRC_NONE;
        req = '0;
        if (alu_valid) begin
            src    = SRC_ALU;
            req.wa = alu_wa;
            req.wd = alu_wd;
        end else if (lu_valid) begin
            src    = SRC_LU;
            req.wa = lu_wa;
            req.wd = lu_wd;
        end
    end

    assign lu_ready = (src == SRC_LU);

    // r0 results are consumed normally but never reach the register file.
    always_comb begin
        we_d  = (src != SRC_NONE) && !is_zero_reg(req.wa);
        out_d = out_q;
        if (src != SRC_NONE) begin
            out_d = req;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q  <= 1'b0;
            out_q <= '0;
        end else begin
            we_q  <= we_d;
            out_q <= out_d;
        end
    end

    assign we = we_q;
    assign wa = out_q.wa;
    assign wd = out_q.wd;

    wb_scoreboard #(
        .LU_MAX (LU_MAX),
        .CNT_W  (CNT_W)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_wa    (issue_wa),
        .issue_long  (issue_long),
        .lu_done     (lu_ready),
        .commit_we   (we_q),
        .commit_wa   (out_q.wa),
        .ra1         (ra1),
        .ra2         (ra2),
        .issue_ready (issue_ready),
        .haz1        (haz1),
        .haz2        (haz2)
    );

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: directed vector table, hand-written corner sequences, randomized model check.
module tb_reg_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_long, issue_ready;
    logic [4:0]  issue_wa;
    logic        alu_valid, lu_valid, lu_ready;
    logic [4:0]  alu_wa, lu_wa, ra1, ra2, wa;
    logic [31:0] alu_wd, lu_wd, wd;
    logic        haz1, haz2, we;

    int tests = 0;
    int fails = 0;

    reg_writeback dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_wa(issue_wa), .issue_long(issue_long),
        .issue_ready(issue_ready),
        .alu_valid(alu_valid), .alu_wa(alu_wa), .alu_wd(alu_wd),
        .lu_valid(lu_valid), .lu_wa(lu_wa), .lu_wd(lu_wd), .lu_ready(lu_ready),
        .ra1(ra1), .ra2(ra2), .haz1(haz1), .haz2(haz2),
        .we(we), .wa(wa), .wd(wd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;  logic [4:0] iwa; logic il;
        logic        av;  logic [4:0] awa; logic [31:0] awd;
        logic        lv;  logic [4:0] lwa; logic [31:0] lwd;
        logic [4:0]  r1;  logic [4:0] r2;
        logic        e_we; logic [4:0] e_wa; logic [31:0] e_wd;
        logic        e_lr; logic e_ir; logic e_h1; logic e_h2;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(
        input logic iv, input logic [4:0] iwa, input logic il,
        input logic av, input logic [4:0] awa, input logic [31:0] awd,
        input logic lv, input logic [4:0] lwa, input logic [31:0] lwd,
        input logic [4:0] r1, input logic [4:0] r2,
        input logic e_we, input logic [4:0] e_wa, input logic [31:0] e_wd,
        input logic e_lr, input logic e_ir, input logic e_h1, input logic e_h2);
        vec_t v;
        v.iv = iv; v.iwa = iwa; v.il = il;
        v.av = av; v.awa = awa; v.awd = awd;
        v.lv = lv; v.lwa = lwa; v.lwd = lwd;
        v.r1 = r1; v.r2 = r2;
        v.e_we = e_we; v.e_wa = e_wa; v.e_wd = e_wd;
        v.e_lr = e_lr; v.e_ir = e_ir; v.e_h1 = e_h1; v.e_h2 = e_h2;
        return v;
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic set_idle();
        issue_valid = 1'b0; issue_wa = 5'd0; issue_long = 1'b0;
        alu_valid = 1'b0; alu_wa = 5'd0; alu_wd = 32'd0;
        lu_valid = 1'b0; lu_wa = 5'd0; lu_wd = 32'd0;
        ra1 = 5'd0; ra2 = 5'd0;
    endtask

    // Inputs change 1 time unit after posedge; outputs are sampled at the following negedge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        set_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic issue(input logic [4:0] a, input logic lng);
        issue_valid = 1'b1; issue_wa = a; issue_long = lng;
    endtask

    // Reference model state for the randomized phase.
    bit          m_pend[32];
    int          m_cnt;
    bit          m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    bit          lu_hold;

    initial begin
        rst = 1'b1;
        set_idle();
        #3;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        issue_long = 1'b1; ra1 = 5'd5; ra2 = 5'd7;
        #4;
        chk1("rst_we", we, 1'b0);
        chk1("rst_lu_ready", lu_ready, 1'b0);
        chk1("rst_issue_ready", issue_ready, 1'b1);
        chk1("rst_haz1", haz1, 1'b0);
        chk1("rst_haz2", haz2, 1'b0);
        tick();
        set_idle();

        //            iv iwa il  av awa awd           lv lwa lwd    r1 r2  we wa wd            lr ir h1 h2
        vecs[0]  = mk(1, 5, 0,   0, 0, 32'h0,         0, 0, 32'h0,  5, 0,  0, 0, 32'h0,        0, 1, 0, 0);
        vecs[1]  = mk(0, 0, 0,   1, 5, 32'hDEADBEEF,  0, 0, 32'h0,  5, 0,  0, 0, 32'h0,        0, 1, 1, 0);
        vecs[2]  = mk(0, 0, 0,   0, 0, 32'h0,         0, 0, 32'h0,  5, 0,  1, 5, 32'hDEADBEEF, 0, 1, 1, 0);
        vecs[3]  = mk(0, 0, 0,   0, 0, 32'h0,         0, 0, 32'h0,  5, 0,  0, 0, 32'h0,        0, 1, 0, 0);
        vecs[4]  = mk(1, 3, 0,   0, 0, 32'h0,         0, 0, 32'h0,  3, 7,  0, 0, 32'h0,        0, 1, 0, 0);
        vecs[5]  = mk(1, 7, 1,   0, 0, 32'h0,         0, 0, 32'h0,  3, 7,  0, 0, 32'h0,        0, 1, 1, 0);
        vecs[6]  = mk(0, 0, 0,   1, 3, 32'h33,        1, 7, 32'h77, 3, 7,  0, 0, 32'h0,        0, 1, 1, 1);
        vecs[7]  = mk(0, 0, 0,   0, 0, 32'h0,         1, 7, 32'h77, 3, 7,  1, 3, 32'h33,       1, 1, 1, 1);
        vecs[8]  = mk(0, 0, 0,   0, 0, 32'h0,         0, 0, 32'h0,  3, 7,  1, 7, 32'h77,       0, 1, 0, 1);
        vecs[9]  = mk(0, 0, 0,   0, 0, 32'h0,         0, 0, 32'h0,  3, 7,  0, 0, 32'h0,        0, 1, 0, 0);
        vecs[10] = mk(1, 0, 0,   1, 0, 32'h1,         0, 0, 32'h0,  0, 0,  0, 0, 32'h0,        0, 1, 0, 0);
        vecs[11] = mk(0, 0, 0,   0, 0, 32'h0,         0, 0, 32'h0,  0, 0,  0, 0, 32'h0,        0, 1, 0, 0);
        vecs[12] = mk(0, 0, 0,   0, 0, 32'h0,         0, 0, 32'h0,  0, 0,  0, 0, 32'h0,        0, 1, 0, 0);

        for (int i = 0; i < 13; i++) begin
            issue_valid = vecs[i].iv; issue_wa = vecs[i].iwa; issue_long = vecs[i].il;
            alu_valid = vecs[i].av; alu_wa = vecs[i].awa; alu_wd = vecs[i].awd;
            lu_valid = vecs[i].lv; lu_wa = vecs[i].lwa; lu_wd = vecs[i].lwd;
            ra1 = vecs[i].r1; ra2 = vecs[i].r2;
            #4;
            chk1($sformatf("vec%0d_we", i), we, vecs[i].e_we);
            chk1($sformatf("vec%0d_lu_ready", i), lu_ready, vecs[i].e_lr);
            chk1($sformatf("vec%0d_issue_ready", i), issue_ready, vecs[i].e_ir);
            chk1($sformatf("vec%0d_haz1", i), haz1, vecs[i].e_h1);
            chk1($sformatf("vec%0d_haz2", i), haz2, vecs[i].e_h2);
            if (vecs[i].e_we) begin
                chk32($sformatf("vec%0d_wa", i), {27'd0, wa}, {27'd0, vecs[i].e_wa});
                chk32($sformatf("vec%0d_wd", i), wd, vecs[i].e_wd);
            end
            tick();
        end
        set_idle();

        // Credit limit: four outstanding long ops exhaust the credits
        for (int i = 0; i < 4; i++) begin
            issue(5'(10 + i), 1'b1);
            #4;
            chk1($sformatf("credit_issue%0d_ready", i), issue_ready, 1'b1);
            tick();
        end
        issue(5'd14, 1'b1);
        #4;
        chk1("credit_full_ready", issue_ready, 1'b0);
        tick();
        lu_valid = 1'b1; lu_wa = 5'd10; lu_wd = 32'hA0;
        #4;
        chk1("credit_swap_lu_ready", lu_ready, 1'b1);
        chk1("credit_swap_issue_ready", issue_ready, 1'b1);
        tick();
        lu_valid = 1'b0;
        issue(5'd15, 1'b1);
        ra1 = 5'd14;
        #4;
        chk1("credit_stays_full", issue_ready, 1'b0);
        chk1("credit_haz_new", haz1, 1'b1);
        chk1("credit_commit_we", we, 1'b1);
        chk32("credit_commit_wd", wd, 32'hA0);
        tick();
        apply_reset();

        // Same-edge commit and re-issue of r9: the new pending bit survives
        issue(5'd9, 1'b0);
        tick();
        set_idle();
        alu_valid = 1'b1; alu_wa = 5'd9; alu_wd = 32'h99; ra1 = 5'd9;
        #4;
        chk1("coll_haz_before", haz1, 1'b1);
        tick();
        set_idle();
        issue(5'd9, 1'b0); ra1 = 5'd9;
        #4;
        chk1("coll_commit_we", we, 1'b1);
        chk32("coll_commit_wa", {27'd0, wa}, 32'd9);
        tick();
        set_idle();
        ra1 = 5'd9;
        alu_valid = 1'b1; alu_wa = 5'd9; alu_wd = 32'h999;
        #4;
        chk1("coll_set_wins", haz1, 1'b1);
        chk1("coll_no_we", we, 1'b0);
        tick();
        set_idle(); ra1 = 5'd9;
        #4;
        chk1("coll_second_we", we, 1'b1);
        tick();
        #4;
        chk1("coll_cleared", haz1, 1'b0);
        tick();

        // Asynchronous reset with pend = 0x104, four credits in use and a write in flight
        issue(5'd2, 1'b1); tick();
        issue(5'd8, 1'b1); tick();
        issue(5'd2, 1'b1); tick();
        issue(5'd8, 1'b1); tick();
        set_idle();
        alu_valid = 1'b1; alu_wa = 5'd8; alu_wd = 32'h88;
        issue_long = 1'b1; ra1 = 5'd2; ra2 = 5'd8;
        #4;
        chk1("rstm_pre_ready", issue_ready, 1'b0);
        chk1("rstm_pre_haz1", haz1, 1'b1);
        chk1("rstm_pre_haz2", haz2, 1'b1);
        @(posedge clk);
        #1;
        alu_valid = 1'b0;
        chk1("rstm_inflight_we", we, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk1("rstm_we", we, 1'b0);
        chk1("rstm_haz1", haz1, 1'b0);
        chk1("rstm_haz2", haz2, 1'b0);
        chk1("rstm_ready", issue_ready, 1'b1);
        tick();
        rst = 1'b0;
        #4;
        chk1("rstm_post_we", we, 1'b0);
        tick();

        // Randomized traffic against the reference model
        apply_reset();
        foreach (m_pend[k]) m_pend[k] = 1'b0;
        m_cnt = 0; m_we = 1'b0; m_wa = 5'd0; m_wd = 32'd0; lu_hold = 1'b0;
        for (int c = 0; c < 500; c++) begin
            bit lr, ir, h1, h2, acc;
            if (!lu_hold) begin
                lu_valid = ($urandom_range(0, 4) == 0);
                lu_wa    = 5'($urandom_range(0, 7));
                lu_wd    = $urandom;
            end
            alu_valid   = ($urandom_range(0, 2) == 0);
            alu_wa      = 5'($urandom_range(0, 7));
            alu_wd      = $urandom;
            issue_valid = 1'($urandom_range(0, 1));
            issue_wa    = 5'($urandom_range(0, 7));
            issue_long  = 1'($urandom_range(0, 1));
            ra1         = 5'($urandom_range(0, 7));
            ra2         = 5'($urandom_range(0, 7));
            #4;
            lr = lu_valid && !alu_valid;
            ir = !issue_long || (m_cnt < 4) || lr;
            h1 = (ra1 != 5'd0) && m_pend[ra1];
            h2 = (ra2 != 5'd0) && m_pend[ra2];
            chk1($sformatf("rnd%0d_lu_ready", c), lu_ready, lr);
            chk1($sformatf("rnd%0d_issue_ready", c), issue_ready, ir);
            chk1($sformatf("rnd%0d_haz1", c), haz1, h1);
            chk1($sformatf("rnd%0d_haz2", c), haz2, h2);
            chk1($sformatf("rnd%0d_we", c), we, m_we);
            if (m_we) begin
                chk32($sformatf("rnd%0d_wa", c), {27'd0, wa}, {27'd0, m_wa});
                chk32($sformatf("rnd%0d_wd", c), wd, m_wd);
            end
            acc = issue_valid && ir;
            if (m_we) m_pend[m_wa] = 1'b0;
            if (acc && issue_wa != 5'd0) m_pend[issue_wa] = 1'b1;
            if (acc && issue_long && !lr) m_cnt++;
            else if (lr && !(acc && issue_long) && m_cnt > 0) m_cnt--;
            if (alu_valid) begin
                m_we = (alu_wa != 5'd0); m_wa = alu_wa; m_wd = alu_wd;
            end else if (lu_valid) begin
                m_we = (lu_wa != 5'd0); m_wa = lu_wa; m_wd = lu_wd;
            end else begin
                m_we = 1'b0;
            end
            lu_hold = lu_valid && !lr;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
